// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg
//   Shared types and helpers for the SDRAM port arbiter.
//   - arb_state_t : arbiter FSM states (SYNC, IDLE, WAIT)
//   - DS_BOTH     : byte-strobe value selecting both bytes
//   - rr_next     : modular round-robin pointer increment
package sdram_arb_pkg;

   typedef enum logic [1:0] {
      SYNC,
      IDLE,
      WAIT
   } arb_state_t;

   localparam logic [1:0] DS_BOTH = 2'b11;

   // Pointer following ptr, wrapping explicitly at n. When client 0 is
   // outside the rotation (skip0), the wrap lands on 1 instead of 0.
   function automatic int unsigned rr_next(input int unsigned ptr,
                                           input int unsigned n,
                                           input bit          skip0);
      if (ptr + 1 >= n) begin
         return skip0 ? 1 : 0;
      end
      return ptr + 1;
   endfunction

endpackage

// File: rtl/sdram_port_arb_rr_pick.sv
// rr_pick
//   Combinational round-robin pick among N_CLIENTS requesters.
//   - req_i   : request vector
//   - ptr_i   : index where the circular scan starts
//   - gnt_o   : one-hot winner
//   - idx_o   : binary index of the winner
//   - valid_o : at least one eligible request
//   With PRIO0 set, client 0 is removed from the rotation and instead
//   overrides the rotating result whenever it requests.
module rr_pick #(
   parameter int unsigned N_CLIENTS = 3,
   parameter bit          PRIO0     = 1'b1,
   localparam int unsigned PW       = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1
) (
   input  logic [N_CLIENTS-1:0] req_i,
   input  logic [PW-1:0]        ptr_i,
   output logic [N_CLIENTS-1:0] gnt_o,
   output logic [PW-1:0]        idx_o,
   output logic                 valid_o
);

   logic [N_CLIENTS-1:0]   req_m;
   logic [N_CLIENTS-1:0]   rot;
   logic [N_CLIENTS-1:0]   gnt_rot;
   logic [2*N_CLIENTS-1:0] gnt_dbl;
   logic                   found;
   int unsigned            pos;

   always_comb begin
      req_m = req_i;
      if (PRIO0) begin
         req_m[0] = 1'b0;
      end

      // Rotate so that bit 0 is the client at ptr_i; the first set bit of
      // the rotated vector is then the round-robin winner.
      rot = N_CLIENTS'({req_m, req_m} >> ptr_i);

      found   = 1'b0;
      gnt_rot = '0;
      pos     = 0;
      for (int unsigned k = 0; k < N_CLIENTS; k++) begin
         if (!found && rot[k]) begin
            found      = 1'b1;
            gnt_rot[k] = 1'b1;
            pos        = 32'(ptr_i) + k;
         end
      end
      if (pos >= N_CLIENTS) begin
         pos = pos - N_CLIENTS;
      end

      // Rotate the one-hot back into client order.
      gnt_dbl = {{N_CLIENTS{1'b0}}, gnt_rot} << ptr_i;
      gnt_o   = gnt_dbl[N_CLIENTS-1:0] | gnt_dbl[2*N_CLIENTS-1:N_CLIENTS];
      idx_o   = PW'(pos);
      valid_o = found;

      if (PRIO0 && req_i[0]) begin
         gnt_o    = '0;
         gnt_o[0] = 1'b1;
         idx_o    = '0;
         valid_o  = 1'b1;
      end
   end

endmodule

// File: rtl/sdram_port_arb.sv
// sdram_port_arb
//   Shares one toggle-handshake SDRAM port between N_CLIENTS requesters.
//   Ports:
//   - clk, reset          : clock, synchronous active-high reset
//   - cl_valid/we/addr/ds/d : per-client request (client i at slice i)
//   - cl_ready            : 1-cycle pulse, request accepted and latched
//   - cl_rvalid           : 1-cycle pulse, read data valid / write done
//   - cl_q                : shared read data, qualified by cl_rvalid
//   - port_req/ack        : toggle handshake; done when ack == req
//   - port_we/a/ds/d      : latched access fields
//   - port_q              : SDRAM read data
//   - busy                : arbiter not in IDLE
//   At most one access is in flight. port_req is deliberately not reset
//   so that it stays in step with a controller whose port is not reset;
//   after reset the SYNC state drains any outstanding access silently.
module sdram_port_arb
   import sdram_arb_pkg::*;
#(
   parameter int unsigned N_CLIENTS = 3,
   parameter bit          PRIO0     = 1'b1,
   parameter int unsigned AW        = 23
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_CLIENTS-1:0]    cl_valid,
   input  logic [N_CLIENTS-1:0]    cl_we,
   input  logic [N_CLIENTS*AW-1:0] cl_addr,
   input  logic [N_CLIENTS*2-1:0]  cl_ds,
   input  logic [N_CLIENTS*16-1:0] cl_d,
   output logic [N_CLIENTS-1:0]    cl_ready,
   output logic [N_CLIENTS-1:0]    cl_rvalid,
   output logic [15:0]             cl_q,
   output logic                    port_req,
   input  logic                    port_ack,
   output logic                    port_we,
   output logic [AW-1:0]           port_a,
   output logic [1:0]              port_ds,
   output logic [15:0]             port_d,
   input  logic [15:0]             port_q,
   output logic                    busy
);

   localparam int unsigned PW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

   arb_state_t           state_q, state_d;
   logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
   logic [PW-1:0]        gnt_q, gnt_d;
   logic [N_CLIENTS-1:0] gnt_oh_q, gnt_oh_d;
   logic [N_CLIENTS-1:0] cl_ready_q, cl_ready_d;
   logic [N_CLIENTS-1:0] cl_rvalid_q, cl_rvalid_d;
   logic [15:0]          cl_q_q, cl_q_d;
   logic                 port_we_q, port_we_d;
   logic [AW-1:0]        port_a_q, port_a_d;
   logic [1:0]           port_ds_q, port_ds_d;
   logic [15:0]          port_d_q, port_d_d;
   logic                 port_req_q = 1'b0;
   logic                 port_req_d;

   logic [N_CLIENTS-1:0] pick_oh;
   logic [PW-1:0]        pick_idx;
   logic                 pick_valid;
   logic                 ack_match;

   assign ack_match = (port_ack == port_req_q);

   rr_pick #(
      .N_CLIENTS (N_CLIENTS),
      .PRIO0     (PRIO0)
   ) u_pick (
      .req_i   (cl_valid),
      .ptr_i   (rr_ptr_q),
      .gnt_o   (pick_oh),
      .idx_o   (pick_idx),
      .valid_o (pick_valid)
   );

   always_ff @(posedge clk) begin : state_reg
      if (reset) begin
         state_q <= SYNC;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin : next_state
      state_d = state_q;
      unique case (state_q)
         SYNC:    if (ack_match)  state_d = IDLE;
         IDLE:    if (pick_valid) state_d = WAIT;
         WAIT:    if (ack_match)  state_d = IDLE;
         default: state_d = SYNC;
      endcase
   end

   always_comb begin : outputs_d
      rr_ptr_d    = rr_ptr_q;
      gnt_d       = gnt_q;
      gnt_oh_d    = gnt_oh_q;
      cl_ready_d  = '0;
      cl_rvalid_d = '0;
      cl_q_d      = cl_q_q;
      port_we_d   = port_we_q;
      port_a_d    = port_a_q;
      port_ds_d   = port_ds_q;
      port_d_d    = port_d_q;
      port_req_d  = port_req_q;
      unique case (state_q)
         IDLE: begin
            if (pick_valid) begin
               port_req_d = ~port_req_q;
               cl_ready_d = pick_oh;
               gnt_d      = pick_idx;
               gnt_oh_d   = pick_oh;
               for (int unsigned i = 0; i < N_CLIENTS; i++) begin
                  if (pick_oh[i]) begin
                     port_we_d = cl_we[i];
                     port_a_d  = cl_addr[i*AW +: AW];
                     port_ds_d = cl_ds[i*2 +: 2];
                     port_d_d  = cl_d[i*16 +: 16];
                  end
               end
            end
         end
         WAIT: begin
            if (ack_match) begin
               cl_rvalid_d = gnt_oh_q;
               if (!port_we_q) begin
                  cl_q_d = port_q;
               end
               rr_ptr_d = PW'(rr_next(32'(gnt_q), N_CLIENTS, PRIO0));
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin : datapath
      if (reset) begin
         rr_ptr_q    <= '0;
         gnt_q       <= '0;
         gnt_oh_q    <= '0;
         cl_ready_q  <= '0;
         cl_rvalid_q <= '0;
         cl_q_q      <= '0;
         port_we_q   <= 1'b0;
         port_a_q    <= '0;
         port_ds_q   <= '0;
         port_d_q    <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         gnt_q       <= gnt_d;
         gnt_oh_q    <= gnt_oh_d;
         cl_ready_q  <= cl_ready_d;
         cl_rvalid_q <= cl_rvalid_d;
         cl_q_q      <= cl_q_d;
         port_we_q   <= port_we_d;
         port_a_q    <= port_a_d;
         port_ds_q   <= port_ds_d;
         port_d_q    <= port_d_d;
      end
   end

   // The toggle only freezes during reset; its value is never cleared.
   always_ff @(posedge clk) begin : req_toggle
      if (!reset) begin
         port_req_q <= port_req_d;
      end
   end

   assign cl_ready  = cl_ready_q;
   assign cl_rvalid = cl_rvalid_q;
   assign cl_q      = cl_q_q;
   assign port_req  = port_req_q;
   assign port_we   = port_we_q;
   assign port_a    = port_a_q;
   assign port_ds   = port_ds_q;
   assign port_d    = port_d_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sdram_port_arb.sv
// tb_sdram_port_arb
//   Scoreboard bench for sdram_port_arb. Instance 0 uses PRIO0 = 0,
//   instance 1 uses PRIO0 = 1. Expected grants are queued when the
//   stimulus is applied and popped when a cl_ready pulse appears.
module tb_sdram_port_arb;

   localparam int unsigned N  = 3;
   localparam int unsigned AW = 23;

   typedef struct {
      int unsigned   cl;
      logic          we;
      logic [AW-1:0] a;
      logic [1:0]    ds;
      logic [15:0]   d;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic [N-1:0]    valid  [2];
   logic [N-1:0]    we     [2];
   logic [N*AW-1:0] addr   [2];
   logic [2*N-1:0]  ds     [2];
   logic [16*N-1:0] d      [2];
   logic [N-1:0]    ready  [2];
   logic [N-1:0]    rvalid [2];
   logic [15:0]     clq    [2];
   logic            preq   [2];
   logic            ack    [2];
   logic            pwe    [2];
   logic [AW-1:0]   pa     [2];
   logic [1:0]      pds    [2];
   logic [15:0]     pd     [2];
   logic [15:0]     pq     [2];
   logic            busy   [2];

   exp_t        sb[$];
   logic        req_m [2];
   logic [15:0] exp_q [2];
   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   sdram_port_arb #(.N_CLIENTS(N), .PRIO0(1'b0), .AW(AW)) u_rr (
      .clk(clk), .reset(reset),
      .cl_valid(valid[0]), .cl_we(we[0]), .cl_addr(addr[0]), .cl_ds(ds[0]), .cl_d(d[0]),
      .cl_ready(ready[0]), .cl_rvalid(rvalid[0]), .cl_q(clq[0]),
      .port_req(preq[0]), .port_ack(ack[0]), .port_we(pwe[0]), .port_a(pa[0]),
      .port_ds(pds[0]), .port_d(pd[0]), .port_q(pq[0]), .busy(busy[0])
   );

   sdram_port_arb #(.N_CLIENTS(N), .PRIO0(1'b1), .AW(AW)) u_p0 (
      .clk(clk), .reset(reset),
      .cl_valid(valid[1]), .cl_we(we[1]), .cl_addr(addr[1]), .cl_ds(ds[1]), .cl_d(d[1]),
      .cl_ready(ready[1]), .cl_rvalid(rvalid[1]), .cl_q(clq[1]),
      .port_req(preq[1]), .port_ack(ack[1]), .port_we(pwe[1]), .port_a(pa[1]),
      .port_ds(pds[1]), .port_d(pd[1]), .port_q(pq[1]), .busy(busy[1])
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [N-1:0] oh(input int unsigned c);
      logic [N-1:0] r;
      r    = '0;
      r[c] = 1'b1;
      return r;
   endfunction

   task automatic setf(input int unsigned s, input int unsigned c, input logic w,
                       input logic [AW-1:0] a, input logic [1:0] b, input logic [15:0] x);
      we[s][c]             = w;
      addr[s][c*AW +: AW]  = a;
      ds[s][c*2 +: 2]      = b;
      d[s][c*16 +: 16]     = x;
   endtask

   task automatic push(input int unsigned s, input int unsigned c);
      exp_t e;
      e.cl = c;
      e.we = we[s][c];
      e.a  = addr[s][c*AW +: AW];
      e.ds = ds[s][c*2 +: 2];
      e.d  = d[s][c*16 +: 16];
      sb.push_back(e);
   endtask

   // Wait for a grant on instance s, check it against the scoreboard head,
   // hold the access for lat cycles, ack it and check the completion.
   task automatic serve(input int unsigned s, input int unsigned lat, input logic [15:0] qv,
                        input logic hold, input logic [N-1:0] on_ack, output int unsigned waited);
      exp_t        e;
      int unsigned w;
      w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (ready[s] == '0 && w < 50);
      waited = w;
      if (sb.size() == 0) begin
         chk("sb_empty", 64'(1), 64'(0));
         return;
      end
      e        = sb.pop_front();
      req_m[s] = ~req_m[s];
      chk("ready",    64'(ready[s]), 64'(oh(e.cl)));
      chk("port_req", 64'(preq[s]),  64'(req_m[s]));
      chk("port_we",  64'(pwe[s]),   64'(e.we));
      chk("port_a",   64'(pa[s]),    64'(e.a));
      chk("port_ds",  64'(pds[s]),   64'(e.ds));
      chk("port_d",   64'(pd[s]),    64'(e.d));
      chk("busy_gnt", 64'(busy[s]),  64'(1));
      if (!hold) valid[s][e.cl] = 1'b0;
      repeat (lat) begin
         @(negedge clk);
         chk("ready_pulse", 64'(ready[s]),  64'(0));
         chk("early_rv",    64'(rvalid[s]), 64'(0));
         chk("hold_a",      64'(pa[s]),     64'(e.a));
         chk("hold_d",      64'(pd[s]),     64'(e.d));
         chk("hold_req",    64'(preq[s]),   64'(req_m[s]));
      end
      ack[s]   = req_m[s];
      pq[s]    = qv;
      valid[s] = valid[s] | on_ack;
      @(negedge clk);
      if (!e.we) exp_q[s] = qv;
      chk("rvalid",  64'(rvalid[s]), 64'(oh(e.cl)));
      chk("cl_q",    64'(clq[s]),    64'(exp_q[s]));
      chk("busy_rv", 64'(busy[s]),   64'(0));
      pq[s] = 16'hDEAD;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset    = 1'b0;
      exp_q[0] = '0;
      exp_q[1] = '0;
      @(negedge clk);
      chk("rst_idle0", 64'(busy[0]), 64'(0));
      chk("rst_idle1", 64'(busy[1]), 64'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned w;
      for (int s = 0; s < 2; s++) begin
         valid[s] = '0; we[s] = '0; addr[s] = '0; ds[s] = '0; d[s] = '0;
         ack[s] = 1'b0; pq[s] = '0; req_m[s] = 1'b0; exp_q[s] = '0;
      end

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_busy",   64'(busy[0]),   64'(1));
      chk("rst_ready",  64'(ready[0]),  64'(0));
      chk("rst_rvalid", 64'(rvalid[0]), 64'(0));
      chk("rst_clq",    64'(clq[0]),    64'(0));
      chk("rst_we",     64'(pwe[0]),    64'(0));
      chk("rst_a",      64'(pa[0]),     64'(0));
      chk("rst_ds",     64'(pds[0]),    64'(0));
      chk("rst_d",      64'(pd[0]),     64'(0));
      chk("rst_req",    64'(preq[0]),   64'(0));
      reset = 1'b0;
      @(negedge clk);
      chk("sync_idle", 64'(busy[0]), 64'(0));

      // Single read, client 1
      setf(0, 1, 1'b0, 23'h012345, 2'b11, 16'h0000);
      valid[0][1] = 1'b1;
      push(0, 1);
      serve(0, 4, 16'hBEEF, 1'b0, '0, w);
      chk("lat_read", 64'(w), 64'(1));
      @(negedge clk);
      chk("rv_pulse", 64'(rvalid[0]), 64'(0));

      // Write, client 0: cl_q keeps the previous read data
      setf(0, 0, 1'b1, 23'h000010, 2'b01, 16'h00A5);
      valid[0][0] = 1'b1;
      push(0, 0);
      serve(0, 3, 16'h1234, 1'b0, '0, w);
      chk("lat_write", 64'(w), 64'(1));

      // Round-robin, PRIO0 = 0, all clients held valid
      do_reset();
      for (int unsigned c = 0; c < N; c++) begin
         setf(0, c, (c == 2), AW'($urandom), 2'(c + 1), 16'($urandom));
         setf(1, c, (c == 1), AW'($urandom), 2'(3 - c), 16'($urandom));
      end
      valid[0] = '1;
      for (int unsigned k = 0; k < 6; k++) begin
         push(0, k % N);
         serve(0, 1 + k, 16'($urandom), 1'b1, '0, w);
         chk("rr_b2b", 64'(w), 64'(1));
      end
      valid[0] = '0;

      // PRIO0 = 1: client 0 dominates, then 1, 2, 1
      valid[1] = '1;
      for (int unsigned k = 0; k < 6; k++) begin
         if (k == 3) valid[1][0] = 1'b0;
         push(1, (k < 3) ? 0 : ((k == 4) ? 2 : 1));
         serve(1, 2, 16'($urandom), 1'b1, '0, w);
         chk("p0_b2b", 64'(w), 64'(1));
      end
      valid[1] = '0;

      // Ack coincident with a new valid from client 1
      setf(0, 0, 1'b0, 23'h000777, 2'b11, 16'h0000);
      valid[0][0] = 1'b1;
      push(0, 0);
      serve(0, 2, 16'h5A5A, 1'b0, 3'b010, w);
      push(0, 1);
      serve(0, 2, 16'hC3C3, 1'b0, '0, w);
      chk("coinc_lat", 64'(w), 64'(1));

      // Reset during WAIT with the access still outstanding
      valid[0][0] = 1'b1;
      @(negedge clk);
      req_m[0] = ~req_m[0];
      chk("mid_ready", 64'(ready[0]), 64'(oh(0)));
      chk("mid_req",   64'(preq[0]),  64'(req_m[0]));
      valid[0][0] = 1'b0;
      valid[0][2] = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("mr_busy", 64'(busy[0]),   64'(1));
         chk("mr_rdy",  64'(ready[0]),  64'(0));
         chk("mr_rv",   64'(rvalid[0]), 64'(0));
         chk("mr_req",  64'(preq[0]),   64'(req_m[0]));
      end
      reset    = 1'b0;
      exp_q[0] = '0;
      exp_q[1] = '0;
      repeat (3) begin
         @(negedge clk);
         chk("drain_busy", 64'(busy[0]),   64'(1));
         chk("drain_rdy",  64'(ready[0]),  64'(0));
         chk("drain_rv",   64'(rvalid[0]), 64'(0));
      end
      chk("drain_clq", 64'(clq[0]), 64'(0));
      ack[0] = req_m[0];
      pq[0]  = 16'h7777;
      @(negedge clk);
      chk("drain_norv", 64'(rvalid[0]), 64'(0));
      chk("drain_nordy", 64'(ready[0]), 64'(0));
      chk("drain_idle", 64'(busy[0]),   64'(0));
      push(0, 2);
      serve(0, 2, 16'h2222, 1'b0, '0, w);
      chk("post_drain_lat", 64'(w), 64'(1));
      chk("sb_drained", 64'(sb.size()), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
